// File: rtl/fifo_vr_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_vr_pkg
//  Purpose : Width helpers shared by the fifo_vr block and its pointer
//            sub-module. The pointer struct itself depends on DEPTH and is
//            therefore declared locally where it is used.
//  Revision: 1.0 - initial release
// ============================================================================
package fifo_vr_pkg;

    // Bits needed to index DEPTH entries (kept at least 1 so a packed
    // range never collapses).
    function automatic int unsigned ptr_bits(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Bits needed to hold an occupancy of 0..DEPTH inclusive.
    function automatic int unsigned cnt_bits(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_ptr
//  Purpose : One FIFO pointer {flag, value}. The value counts 0..DEPTH-1 and
//            wraps to 0; the flag toggles on every wrap so that equal values
//            with differing flags mean "one lap apart" (full).
//  Ports   : clk_i   - clock, rising edge
//            rst_i   - asynchronous active-high reset (pointer -> 0)
//            inc_i   - advance the pointer by one
//            clr_i   - return the pointer to zero (wins over inc_i)
//            flag_o  - wrap flag
//            value_o - index 0..DEPTH-1
//  Revision: 1.0 - initial release
// ============================================================================
module fifo_ptr
    import fifo_vr_pkg::*;
#(
    parameter  int DEPTH     = 8,
    localparam int PTR_WIDTH = ptr_bits(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic                 flag_o,
    output logic [PTR_WIDTH-1:0] value_o
);

    localparam logic [PTR_WIDTH-1:0] c_last = PTR_WIDTH'(DEPTH - 1);

    logic                 r_flag;
    logic [PTR_WIDTH-1:0] r_value;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flag  <= 1'b0;
            r_value <= '0;
        end else if (clr_i) begin
            r_flag  <= 1'b0;
            r_value <= '0;
        end else if (inc_i) begin
            // Explicit wrap: DEPTH need not be a power of two.
            if (r_value == c_last) begin
                r_value <= '0;
                r_flag  <= ~r_flag;
            end else begin
                r_value <= r_value + 1'b1;
            end
        end
    end

    assign flag_o  = r_flag;
    assign value_o = r_value;

endmodule
`default_nettype wire

// File: rtl/fifo_vr.sv
`default_nettype none
// ============================================================================
//  Module  : fifo_vr
//  Purpose : Synchronous FIFO of arbitrary DEPTH with valid/ready on both
//            sides, occupancy count, almost-full/almost-empty flags and a
//            synchronous flush. Write-to-read latency is one cycle (no
//            empty bypass).
//  Ports   : clk_i, rst_i         - clock / async active-high reset
//            flush_i              - synchronous clear, beats push and pop
//            in_valid_i/in_ready_o/in_data_i    - write handshake
//            out_valid_o/out_ready_i/out_data_o - read handshake
//            count_o              - occupancy 0..DEPTH
//            full_o, empty_o      - count == DEPTH / count == 0
//            almost_full_o        - count >= AF_LEVEL
//            almost_empty_o       - count <= AE_LEVEL
//  Revision: 1.0 - initial release
// ============================================================================
module fifo_vr
    import fifo_vr_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 8,
    parameter  int AF_LEVEL   = DEPTH - 1,
    parameter  int AE_LEVEL   = 1,
    localparam int PTR_WIDTH  = ptr_bits(DEPTH),
    localparam int CNT_WIDTH  = cnt_bits(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    typedef struct packed {
        logic                 flag;
        logic [PTR_WIDTH-1:0] value;
    } ptr_t;

    ptr_t                  w_head;
    ptr_t                  w_tail;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_WIDTH-1:0]  w_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Handshakes are qualified only by registered status, so out_ready_i
    // never reaches in_ready_o: a full FIFO refuses a push even while it
    // is being popped.
    assign w_push = in_valid_i  & in_ready_o;
    assign w_pop  = out_valid_o & out_ready_i;

    fifo_ptr #(
        .DEPTH   (DEPTH)
    ) u_head (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_push),
        .clr_i   (flush_i),
        .flag_o  (w_head.flag),
        .value_o (w_head.value)
    );

    fifo_ptr #(
        .DEPTH   (DEPTH)
    ) u_tail (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_pop),
        .clr_i   (flush_i),
        .flag_o  (w_tail.flag),
        .value_o (w_tail.value)
    );

    // Storage: a flushed push is discarded, contents otherwise survive flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            r_mem[w_head.value] <= in_data_i;
        end
    end

    // Occupancy: same lap -> plain difference; head one lap ahead ->
    // distance through the wrap point.
    always_comb begin
        w_count = '0;
        if (w_head.flag == w_tail.flag) begin
            w_count = CNT_WIDTH'(w_head.value) - CNT_WIDTH'(w_tail.value);
        end else begin
            w_count = CNT_WIDTH'(DEPTH) - CNT_WIDTH'(w_tail.value)
                    + CNT_WIDTH'(w_head.value);
        end
    end

    assign empty_o        = (w_head == w_tail);
    assign full_o         = (w_head.flag != w_tail.flag) &&
                            (w_head.value == w_tail.value);
    assign in_ready_o     = ~full_o;
    assign out_valid_o    = ~empty_o;
    assign out_data_o     = r_mem[w_tail.value];
    assign count_o        = w_count;
    assign almost_full_o  = (w_count >= CNT_WIDTH'(AF_LEVEL));
    assign almost_empty_o = (w_count <= CNT_WIDTH'(AE_LEVEL));

endmodule
`default_nettype wire

// File: tb/tb_fifo_vr.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fifo_vr
//  Purpose : Self-checking bench for fifo_vr (DATA_WIDTH=8, DEPTH=5,
//            AF_LEVEL=4, AE_LEVEL=1). The driver pushes every accepted
//            payload into an expected-data queue; a monitor on the falling
//            edge compares status against the queue occupancy and pops the
//            queue whenever the DUT hands out an entry.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_vr;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic          almost_empty_o;

    fifo_vr #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];   // reference FIFO contents, head first
    int            pend_push = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge. The queue at that
    // point reflects the FIFO after that edge, so acceptance is decided by
    // its size alone.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
        @(posedge clk);
        #2;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        if (v && !f && exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
            pend_push = 1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"},   32'(count_o),        32'd0);
        chk({tag, "_inrdy"},   32'(in_ready_o),     32'd1);
        chk({tag, "_outvld"},  32'(out_valid_o),    32'd0);
        chk({tag, "_outdata"}, 32'(out_data_o),     32'd0);
        chk({tag, "_empty"},   32'(empty_o),        32'd1);
        chk({tag, "_full"},    32'(full_o),         32'd0);
        chk({tag, "_ae"},      32'(almost_empty_o), 32'd1);
        chk({tag, "_af"},      32'(almost_full_o),  32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        in_data_i   = '0;
        exp_q.delete();
        pend_push   = 0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #2;
        rst_i = 1'b0;
    endtask

    // Monitor: status check and data pop, sampled mid-cycle.
    initial begin
        int            n;
        logic [DW-1:0] exp_d;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                pend_push = 0;
            end else begin
                n = exp_q.size() - pend_push;
                chk("count",     32'(count_o),        32'(n));
                chk("empty",     32'(empty_o),        32'(n == 0));
                chk("full",      32'(full_o),         32'(n == DEPTH));
                chk("alm_full",  32'(almost_full_o),  32'(n >= AF));
                chk("alm_empty", 32'(almost_empty_o), 32'(n <= AE));
                chk("in_ready",  32'(in_ready_o),     32'(n < DEPTH));
                chk("out_valid", 32'(out_valid_o),    32'(n > 0));
                if (flush_i) begin
                    exp_q.delete();
                end else if (out_ready_i && n > 0) begin
                    exp_d = exp_q.pop_front();
                    chk("pop_data", 32'(out_data_o), 32'(exp_d));
                end
                pend_push = 0;
            end
        end
    end

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        in_data_i   = '0;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #2;
        rst_i = 1'b0;

        // Fill 0x11..0x15, sixth push must be refused.
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Drain all five in order.
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Hold count at 2 across the pointer wrap.
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) drive(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Full with simultaneous push and pop: pop only.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Down to 3, then flush with a same-cycle push of 0xAA.
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset mid-stream with 3 entries, then 0x5A must come out first.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        do_reset("midrst");
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                  ($urandom % 40) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
